// File: rtl/serial_subtractor4.sv
// Bit-serial WIDTH-bit subtractor (A - B - borrow-in), LSB first, one bit per cycle.
// Defining SERIAL_SUB_OVERFLOW_EN adds a signed Overflow output.
//
// state | meaning
// IDLE  | waiting for Start
// RUN   | shifting operands, one difference bit per cycle
// DONE  | one-cycle result-valid pulse; Start here restarts immediately
module serial_subtractor4 #(
    parameter int WIDTH = 4
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             Start,
    input  logic [WIDTH-1:0] InputA,
    input  logic [WIDTH-1:0] InputB,
    input  logic             InputBorrow,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Output,
    output logic             OutputBorrow
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             Overflow
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT            stateQ, stateD;
    logic [WIDTH-1:0] regA, regB, regRes;
    logic             borrowQ;
    logic [CW-1:0]    bitCount;

    logic             accept;
    logic             lastBit;
    logic             diffBit;
    logic             borrowNext;

    assign diffBit    = regA[0] ^ regB[0] ^ borrowQ;
    assign borrowNext = (~regA[0] & regB[0]) | (~(regA[0] ^ regB[0]) & borrowQ);
    assign lastBit    = (bitCount == CW'(WIDTH - 1));

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        accept = 1'b0;
        Busy   = (stateQ == RUN);
        Done   = (stateQ == DONE);
        case (stateQ)
            IDLE: begin
                if (Start) begin
                    accept = 1'b1;
                    stateD = RUN;
                end
            end
            RUN: begin
                if (lastBit) begin
                    stateD = DONE;
                end
            end
            DONE: begin
                if (Start) begin
                    accept = 1'b1;
                    stateD = RUN;
                end else begin
                    stateD = IDLE;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    // Result bits enter at the MSB so the first (LSB) bit lands in bit 0 after WIDTH shifts.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            regA         <= '0;
            regB         <= '0;
            regRes       <= '0;
            borrowQ      <= 1'b0;
            bitCount     <= '0;
            Output       <= '0;
            OutputBorrow <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            Overflow     <= 1'b0;
`endif
        end else if (accept) begin
            regA     <= InputA;
            regB     <= InputB;
            regRes   <= '0;
            borrowQ  <= InputBorrow;
            bitCount <= '0;
        end else if (stateQ == RUN) begin
            regA     <= regA >> 1;
            regB     <= regB >> 1;
            regRes   <= {diffBit, regRes[WIDTH-1:1]};
            borrowQ  <= borrowNext;
            bitCount <= bitCount + 1'b1;
            if (lastBit) begin
                Output       <= {diffBit, regRes[WIDTH-1:1]};
                OutputBorrow <= borrowNext;
`ifdef SERIAL_SUB_OVERFLOW_EN
                // borrowQ here is the borrow into the MSB stage
                Overflow     <= borrowQ ^ borrowNext;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor4.sv
// Directed self-checking bench for serial_subtractor4 (WIDTH=4).
// Overflow checks are compiled in when SERIAL_SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor4;

    logic       Clock = 1'b0;
    logic       ResetN;
    logic       Start;
    logic [3:0] InputA;
    logic [3:0] InputB;
    logic       InputBorrow;
    logic       Busy;
    logic       Done;
    logic [3:0] Output;
    logic       OutputBorrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic       Overflow;
`endif

    int nCompared   = 0;
    int nMismatched = 0;

    serial_subtractor4 #(.WIDTH(4)) dut (
        .Clock        (Clock),
        .ResetN       (ResetN),
        .Start        (Start),
        .InputA       (InputA),
        .InputB       (InputB),
        .InputBorrow  (InputBorrow),
        .Busy         (Busy),
        .Done         (Done),
        .Output       (Output),
        .OutputBorrow (OutputBorrow)
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .Overflow     (Overflow)
`endif
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        assert (observed === expected)
        else begin
            nMismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic startOp(input logic [3:0] a, input logic [3:0] b, input logic bin);
        InputA      = a;
        InputB      = b;
        InputBorrow = bin;
        Start       = 1'b1;
        step();
        Start       = 1'b0;
    endtask

    task automatic runOp(input string tag, input logic [3:0] a, input logic [3:0] b, input logic bin,
                         input logic [3:0] expOut, input logic expBorrow, input logic expOvf);
        startOp(a, b, bin);
        for (int i = 0; i < 4; i++) begin
            check({tag, " busy"}, 32'(Busy), 32'd1);
            check({tag, " done-early"}, 32'(Done), 32'd0);
            step();
        end
        check({tag, " done"}, 32'(Done), 32'd1);
        check({tag, " busy-off"}, 32'(Busy), 32'd0);
        check({tag, " out"}, 32'(Output), 32'(expOut));
        check({tag, " borrow"}, 32'(OutputBorrow), 32'(expBorrow));
`ifdef SERIAL_SUB_OVERFLOW_EN
        check({tag, " ovf"}, 32'(Overflow), 32'(expOvf));
`endif
    endtask

    initial begin
        ResetN      = 1'b0;
        Start       = 1'b0;
        InputA      = 4'h0;
        InputB      = 4'h0;
        InputBorrow = 1'b0;
        step();
        step();
        check("rst busy", 32'(Busy), 32'd0);
        check("rst done", 32'(Done), 32'd0);
        check("rst out", 32'(Output), 32'd0);
        check("rst borrow", 32'(OutputBorrow), 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        check("rst ovf", 32'(Overflow), 32'd0);
`endif
        ResetN = 1'b1;
        step();

        runOp("7-3", 4'd7, 4'd3, 1'b0, 4'h4, 1'b0, 1'b0);
        step();
        check("idle after 7-3", 32'(Done), 32'd0);
        runOp("3-7", 4'd3, 4'd7, 1'b0, 4'hC, 1'b1, 1'b0);
        runOp("0-0-1", 4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0);

        // reset during the second RUN cycle aborts the operation
        startOp(4'd6, 4'd1, 1'b0);
        step();
        ResetN = 1'b0;
        Start  = 1'b1;
        step();
        check("abort busy", 32'(Busy), 32'd0);
        check("abort done", 32'(Done), 32'd0);
        check("abort out", 32'(Output), 32'd0);
        check("abort borrow", 32'(OutputBorrow), 32'd0);
        step();
        check("start in reset", 32'(Busy), 32'd0);
        ResetN = 1'b1;
        Start  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("no done after abort", 32'(Done), 32'd0);
            check("idle after abort", 32'(Busy), 32'd0);
        end

        // Start during RUN must be ignored
        startOp(4'd5, 4'd2, 1'b0);
        InputA = 4'd9;
        InputB = 4'd9;
        Start  = 1'b1;
        step();
        Start  = 1'b0;
        check("ign busy", 32'(Busy), 32'd1);
        check("ign done", 32'(Done), 32'd0);
        step();
        step();
        check("ign out stable", 32'(Output), 32'd0);
        step();
        check("ign done", 32'(Done), 32'd1);
        check("ign out", 32'(Output), 32'd3);
        check("ign borrow", 32'(OutputBorrow), 32'd0);
        step();
        check("no 2nd op busy", 32'(Busy), 32'd0);
        check("no 2nd op done", 32'(Done), 32'd0);
        check("no 2nd op hold", 32'(Output), 32'd3);

        // back-to-back: Start held through DONE
        runOp("5-2", 4'd5, 4'd2, 1'b0, 4'h3, 1'b0, 1'b0);
        InputA = 4'd9;
        InputB = 4'd9;
        Start  = 1'b1;
        step();
        Start  = 1'b0;
        check("b2b busy", 32'(Busy), 32'd1);
        check("b2b done", 32'(Done), 32'd0);
        check("b2b out held", 32'(Output), 32'd3);
        for (int i = 0; i < 3; i++) begin
            step();
            check("b2b run", 32'(Busy), 32'd1);
            check("b2b run out held", 32'(Output), 32'd3);
        end
        step();
        check("b2b done", 32'(Done), 32'd1);
        check("b2b out", 32'(Output), 32'd0);
        check("b2b borrow", 32'(OutputBorrow), 32'd0);

        runOp("8-1", 4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b1);
        runOp("7-1", 4'h7, 4'h1, 1'b0, 4'h6, 1'b0, 1'b0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/serial_subtractor4.md
SERIAL_SUBTRACTOR4 -- requirements
Module: serial_subtractor4

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, meaning operand/result width in bits (legal range 2..32).
REQ-002 SHALL use one clock; reset is synchronous and active-low.
REQ-003 SHALL provide port Clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL provide port ResetN  input  1  synchronous active-low reset.
REQ-005 SHALL provide port Start  input  1  request to begin a subtraction.
REQ-006 SHALL provide port InputA  input  WIDTH  minuend, sampled only when Start is accepted.
REQ-007 SHALL provide port InputB  input  WIDTH  subtrahend, sampled only when Start is accepted.
REQ-008 SHALL provide port InputBorrow  input  1  borrow-in, sampled only when Start is accepted.
REQ-009 SHALL provide port Busy  output  1  high while an operation is in progress (RUN state).
REQ-010 SHALL provide port Done  output  1  one-cycle pulse when a new result is valid.
REQ-011 SHALL provide port Output  output  WIDTH  difference A - B - InputBorrow, modulo 2^WIDTH.
REQ-012 SHALL provide port OutputBorrow  output  1  borrow-out from the MSB (1 when A < B + InputBorrow, unsigned).

Function
REQ-013 SHALL implement states IDLE, RUN, DONE; Busy = (state == RUN); Done = (state == DONE).
REQ-014 SHALL accept Start in IDLE or DONE; acceptance latches A, B, InputBorrow into internal shift registers and the borrow flop, clears the bit counter, and enters RUN.
REQ-015 SHALL ignore Start while in RUN; latched operands stay unchanged.
REQ-016 SHALL process one bit per RUN cycle, LSB first: d = a ^ b ^ br; br_next = (~a & b) | (~(a ^ b) & br).
REQ-017 SHALL shift each d into the MSB of an internal result register, shifting it right, so that after WIDTH cycles bit 0 holds the first computed bit.
REQ-018 SHALL stay in RUN for exactly WIDTH cycles (counter 0..WIDTH-1), then enter DONE.
REQ-019 SHALL copy the internal result to Output and the final borrow to OutputBorrow on the RUN->DONE transition; both hold until the next completion.
REQ-020 SHALL give latency WIDTH+1: Start accepted at edge N gives Done high during the cycle after edge N+WIDTH (WIDTH=4: Done in the 5th cycle after acceptance).
REQ-021 SHALL leave DONE after one cycle: to RUN if Start is high (back-to-back, no idle cycle), else to IDLE.
REQ-022 SHALL keep Output and OutputBorrow stable during RUN; intermediate bits are never visible.

Reset
REQ-023 SHALL, when ResetN is low at a rising edge, enter IDLE and clear Busy, Done, Output, OutputBorrow, the shift registers, the counter and the borrow flop to 0.
REQ-024 SHALL abort an operation in progress on reset, with no Done pulse for it.
REQ-025 SHALL ignore Start in any cycle where ResetN is low.

Configuration
REQ-026 SHALL, when macro SERIAL_SUB_OVERFLOW_EN is defined, add port Overflow  output  1  signed two's-complement overflow, computed as the borrow into the MSB XOR the borrow out of the MSB, updated and held like OutputBorrow, and reset to 0.
REQ-027 SHALL, when SERIAL_SUB_OVERFLOW_EN is undefined, have no Overflow port or logic, and all other behaviour SHALL be identical.

Verification
REQ-028 SHALL test, with WIDTH=4: A=7, B=3, Bin=0, Start pulse -> Busy for 4 cycles, Done in the 5th cycle, Output=4, OutputBorrow=0.
REQ-029 SHALL test A=3, B=7, Bin=0 -> Output=0xC, OutputBorrow=1; and A=0, B=0, Bin=1 -> Output=0xF, OutputBorrow=1.
REQ-030 SHALL test A=5, B=2, then Start pulsed with A=9, B=9 during RUN -> Output=3 and no second operation; then Start held through DONE with A=9, B=9 -> immediate RUN, next Done gives Output=0.
REQ-031 SHALL test ResetN low in the 2nd RUN cycle of A=6, B=1 -> IDLE next cycle, all outputs 0, no Done pulse.
REQ-032 SHALL test, with SERIAL_SUB_OVERFLOW_EN defined: A=0x8, B=0x1 -> Output=0x7, Overflow=1; A=0x7, B=0x1 -> Output=0x6, Overflow=0.
